// File: rtl/obd_uart_pkg.sv
// Shared types and constants for the OBD2 adapter UART receiver.
package obd_uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // The adapter's command prompt character '>'.
  localparam logic [7:0] PROMPT_CHAR = 8'h3E;

  // Clock cycles per 1/16-bit oversample tick, truncated, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/obd_sync_fifo.sv
// Show-ahead synchronous FIFO with simultaneous push/pop.
// Handshake: push_i is accepted when not full, or when full and a pop is
// accepted in the same cycle; pop_i is accepted only when not empty and is
// otherwise ignored. head_o is the oldest entry whenever empty_o is low and
// reads as zero when empty.
module obd_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written on accepted push, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obd_uart_rx.sv
// 8N1 UART receiver for the OBD2 adapter link: synchroniser, 16x oversample
// tick, frame FSM, byte FIFO and sticky prompt/framing/overrun status.
module obd_uart_rx
  import obd_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 38400,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock_50_clk,
  input  logic                          reset_reset_n,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          prompt_seen,
  input  logic                          prompt_clr,
  output logic                          framing_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [2:0]                    dbg_state_o
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  rx_state_e        state_q;
  logic [3:0]       sc_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             push_q;
  logic [7:0]       push_data_q;
  logic             stop_err_q;
  logic             prompt_q;
  logic             framing_q;
  logic             overrun_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_ok;
  logic             push_ok;
  logic             push_drop;
  logic             prompt_set;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Oversample divider: free-runs while idle, realigned to 0 on start detection.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_q <= '0;
    end else if (state_q == ST_IDLE && !rx_sync_q) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DIV_W'(DIV - 1)) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  assign tick = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));

  // Frame FSM with registered push and stop-error pulses.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      stop_err_q  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      stop_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            state_q <= ST_START;
            sc_q    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sc_q == 4'd7) begin
              if (!rx_sync_q) begin
                state_q <= ST_DATA;
                sc_q    <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            sc_q <= sc_q + 4'd1;
            if (sc_q == 4'd15) begin
              shift_q <= {rx_sync_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            sc_q <= sc_q + 4'd1;
            if (sc_q == 4'd15) begin
              if (rx_sync_q) begin
                push_q      <= 1'b1;
                push_data_q <= shift_q;
                state_q     <= ST_IDLE;
              end else begin
                stop_err_q <= 1'b1;
                state_q    <= ST_BREAK;
              end
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  assign pop_ok     = rd_en && !fifo_empty;
  assign push_ok    = push_q && (!fifo_full || pop_ok);
  assign push_drop  = push_q && fifo_full && !pop_ok;
  assign prompt_set = push_ok && (push_data_q == PROMPT_CHAR);

  obd_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i       (clock_50_clk),
    .rst_ni      (reset_reset_n),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (rd_en),
    .head_o      (rd_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prompt_q  <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prompt_q  <= prompt_set | (prompt_q  & ~prompt_clr);
      framing_q <= stop_err_q | (framing_q & ~err_clr);
      overrun_q <= push_drop  | (overrun_q & ~err_clr);
    end
  end

  assign rd_valid    = !fifo_empty;
  assign prompt_seen = prompt_q;
  assign framing_err = framing_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/obd_uart_rx.md
# obd_uart_rx

UART receiver for the OBD2 adapter link, sitting directly upstream of the controller's byte interface. It deserialises the adapter's 8N1 stream on `UART_RX` and buffers received bytes in a small FIFO that the controller drains. It also flags the adapter's `>` command prompt so firmware knows a response is complete. Framing errors and overruns are reported as sticky status.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `BAUD`, default 38400: line rate.
- `FIFO_DEPTH`, default 16: bytes buffered; power of two, minimum 2.

Ports:
- `clock_50_clk`, in, 1: the single clock.
- `reset_reset_n`, in, 1: asynchronous, active-low reset.
- `uart_rx`, in, 1: serial line; asynchronous, idle high.
- `rd_en`, in, 1: pop the head byte.
- `rd_data`, out, 8: head byte; show-ahead, valid while `rd_valid`=1.
- `rd_valid`, out, 1: FIFO not empty.
- `fifo_count`, out, clog2(FIFO_DEPTH)+1: bytes held.
- `prompt_seen`, out, 1: sticky; set when 0x3E is stored.
- `prompt_clr`, in, 1: clears `prompt_seen`.
- `framing_err`, out, 1: sticky; stop bit was low.
- `overrun`, out, 1: sticky; a byte arrived while the FIFO was full.
- `err_clr`, in, 1: clears `framing_err` and `overrun`.

## Operation
- Input path: 2-FF synchroniser on `uart_rx`; both flops reset to 1.
- Oversample tick:
  - DIV = CLK_HZ/(16*BAUD), truncated; clamp to a minimum of 1. At defaults DIV = 81.
  - Tick counter 0..DIV-1. It free-runs in IDLE and is held at 0 on IDLE exit, so the first tick lands DIV cycles after start detection.
- FSM states: IDLE, START, DATA, STOP, BREAK. Tick counter `sc` counts 0..15.
  - IDLE: synchronised rx=0 → START, `sc`=0.
  - START: on tick with `sc`=7 (mid-bit), rx=0 → DATA with `sc`=0 and `bit`=0; rx=1 → IDLE (glitch rejected, no error).
  - DATA: on tick with `sc`=15, shift rx in LSB-first. After bit 7 → STOP.
  - STOP: on tick with `sc`=15, rx=1 → push the byte, go to IDLE. rx=0 → set `framing_err`, discard the byte, go to BREAK.
  - BREAK: wait for synchronised rx=1, then → IDLE.
- FIFO push:
  - Not full → store the byte. If the byte is 8'h3E, set `prompt_seen`; the `>` is still stored.
  - Full with no pop this cycle → drop the byte and set `overrun`; `prompt_seen` is not affected.
  - Full with a pop in the same cycle → push accepted; count unchanged.
- FIFO pop:
  - `rd_en` with `rd_valid`=1 removes the head.
  - `rd_en` while empty is ignored; count and pointers are unchanged.
- Sticky flags: set has priority over clear in the same cycle.
- Reset mid-frame: abandon the frame, return to IDLE, empty the FIFO, clear all flags.

## Timing
- Reset values: `rd_valid`=0, `fifo_count`=0, `rd_data`=0, `prompt_seen`=0, `framing_err`=0, `overrun`=0; FSM in IDLE.
- Input latency: 2 cycles from a pin edge to the FSM seeing it.
- Start detection to stop-bit sample: (8+16*9)*DIV cycles, ±1 tick of phase error.
- The byte is visible 1 cycle after the stop-bit sample: `rd_valid`, `fifo_count`, and flags all update together.
- `rd_data`/`rd_valid`/`fifo_count` reflect a pop on the cycle after `rd_en`.
- Throughput: back-to-back frames with no idle gap must be received; the FSM is back in IDLE before the next start edge.

## Structure
- Package `obd_uart_pkg`:
  - FSM state enum.
  - `PROMPT_CHAR` = 8'h3E.
  - Function computing DIV with the minimum-of-1 clamp.
- Sub-module `obd_sync_fifo`: depth/width parameterised show-ahead FIFO with simultaneous push/pop, `count`, `full`, and `empty`.
- Top of this block: synchroniser, tick generator, FSM, and flags.

## Test plan
Bench uses CLK_HZ=6_400_000, BAUD=100_000 (DIV=4).
- Single frame 8'hA5, 8N1 → after the stop sample: `rd_data`=A5, `fifo_count`=1, no flags; `rd_en` → `rd_valid`=0.
- 1.5-tick low glitch on an idle line → no byte, no flags, FSM back in IDLE.
- Frame 8'h41 with stop bit low, then line high → `framing_err`=1, `fifo_count`=0. The following frame 8'h42 is received correctly.
- 17 back-to-back frames 0x00..0x10, no pops → count=16, `overrun`=1, head=0x00, 0x10 lost. Then pop on the same cycle as the 18th push: accepted, count stays 16.
- Bytes "41 0D 3E" → `prompt_seen`=1 after the third byte, `fifo_count`=3. `prompt_clr` asserted on the same cycle as a new 0x3E push → stays 1.
- Assert reset mid-DATA with 3 bytes buffered → all outputs at reset values. The next clean frame 8'h5A is received.
